// File: rtl/flash_sample_reader_pkg.sv
// Shared types and constants for the flash sample playback engine.
package flash_sample_reader_pkg;

  localparam int unsigned FLASH_ADDR_W = 23;
  localparam logic [FLASH_ADDR_W-1:0] FLASH_FIRST_ADDR = '0;
  localparam logic [FLASH_ADDR_W-1:0] FLASH_LAST_ADDR  = 23'h7FFFF;

  localparam logic FWD = 1'b1;
  localparam logic BWD = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    OUT_FIRST,
    OUT_SECOND,
    ADVANCE
  } state_t;

  // Forward order plays the low half first; backward plays the high half first.
  function automatic logic signed [15:0] select_half(input logic [31:0] word,
                                                     input logic        fwd_order,
                                                     input logic        second);
    select_half = (fwd_order ^ second) ? word[15:0] : word[31:16];
  endfunction

endpackage

// File: rtl/flash_sample_reader_addr_counter.sv
// Up/down word-address counter that wraps at both ends of the sample region
// and can be loaded with the direction-dependent start address.
module flash_addr_counter
  import flash_sample_reader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FLASH_LAST_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              load_start,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(FLASH_FIRST_ADDR);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (step) begin
      if (load_start) begin
        addr_d = (dir == FWD) ? FIRST_ADDR : LAST_ADDR;
      end else if (dir == FWD) begin
        addr_d = (addr_q == LAST_ADDR) ? FIRST_ADDR : addr_q + ADDR_W'(1);
      end else begin
        addr_d = (addr_q == FIRST_ADDR) ? LAST_ADDR : addr_q - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= FIRST_ADDR;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/flash_sample_reader.sv
// Fetches 32-bit words from flash over Avalon-MM and plays them out as two
// signed 16-bit samples, one per audio tick, forward or backward with wrap.
module flash_sample_reader
  import flash_sample_reader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FLASH_LAST_ADDR)
) (
  input  logic              inclk,
  input  logic              reset,
  input  logic              start_read_flash,
  input  logic              direction,
  input  logic              restart,
  input  logic              sample_tick,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [15:0]       audio_sample,
  output logic              flash_read_finished
);

  state_t             state_q, state_d;
  logic               tick_pending_q, tick_pending_d;
  logic [31:0]        word_q, word_d;
  logic               fwd_order_q, fwd_order_d;
  logic signed [15:0] audio_q, audio_d;
  logic               consume;
  logic               addr_step;

  // A tick is only spent while playing and while a sample is waiting to go out.
  assign consume = ((state_q == OUT_FIRST) || (state_q == OUT_SECOND)) &&
                   tick_pending_q && start_read_flash;

  assign tick_pending_d = consume ? 1'b0
                                  : (tick_pending_q | (sample_tick & start_read_flash));

  always_comb begin
    state_d             = state_q;
    word_d              = word_q;
    fwd_order_d         = fwd_order_q;
    audio_d             = audio_q;
    flash_mem_read      = 1'b0;
    flash_read_finished = 1'b0;
    addr_step           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_read_flash) state_d = REQ;
      end
      REQ: begin
        flash_mem_read = 1'b1;
        if (!flash_mem_waitrequest) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          word_d      = flash_mem_readdata;
          fwd_order_d = direction;
          state_d     = OUT_FIRST;
        end
      end
      OUT_FIRST: begin
        if (consume) begin
          audio_d = select_half(word_q, fwd_order_q, 1'b0);
          state_d = OUT_SECOND;
        end
      end
      OUT_SECOND: begin
        if (consume) begin
          audio_d = select_half(word_q, fwd_order_q, 1'b1);
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        flash_read_finished = 1'b1;
        addr_step           = 1'b1;
        state_d             = start_read_flash ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inclk) begin
    if (reset) begin
      state_q        <= IDLE;
      tick_pending_q <= 1'b0;
      word_q         <= '0;
      fwd_order_q    <= FWD;
      audio_q        <= '0;
    end else begin
      state_q        <= state_d;
      tick_pending_q <= tick_pending_d;
      word_q         <= word_d;
      fwd_order_q    <= fwd_order_d;
      audio_q        <= audio_d;
    end
  end

  flash_addr_counter #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_addr_counter (
    .clk        (inclk),
    .reset      (reset),
    .step       (addr_step),
    .load_start (restart),
    .dir        (direction),
    .addr       (flash_mem_address)
  );

  assign flash_mem_byteenable = 4'hF;
  assign audio_sample         = audio_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Bench for flash_sample_reader: directed reset/stall checks, then scripted and
// random playback scored against a word-level reference model.
module tb_flash_sample_reader;

  localparam logic [22:0] LAST = 23'h7FFFF;

  logic        inclk = 1'b0;
  logic        reset;
  logic        start_read_flash;
  logic        direction;
  logic        restart;
  logic        sample_tick;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic [15:0] audio_sample;
  logic        flash_read_finished;

  always #5 inclk = ~inclk;

  flash_sample_reader dut (
    .inclk                   (inclk),
    .reset                   (reset),
    .start_read_flash        (start_read_flash),
    .direction               (direction),
    .restart                 (restart),
    .sample_tick             (sample_tick),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .audio_sample            (audio_sample),
    .flash_read_finished     (flash_read_finished)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] mem [int unsigned];
  logic [22:0] rd_q  [$];
  logic [22:0] fin_q [$];
  logic [15:0] aud_q [$];
  bit          slave_en = 1'b0;
  bit          mon_en   = 1'b0;

  function automatic logic [31:0] get_word(input logic [22:0] a);
    if (!mem.exists(int'(a))) mem[int'(a)] = $urandom;
    return mem[int'(a)];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected DUT event with value %0h, required none", name, act);
  endtask

  // Avalon slave: random waitrequest stall and random read latency.
  initial begin
    logic [22:0] a;
    int          ws;
    int          lat;
    flash_mem_waitrequest   = 1'b1;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = '0;
    forever begin
      @(posedge inclk); #1;
      if (slave_en && flash_mem_read) begin
        a  = flash_mem_address;
        ws = $urandom_range(0, 7);
        repeat (ws) begin
          @(posedge inclk); #1;
          check("req_hold", {8'd0, flash_mem_read, flash_mem_address}, {8'd0, 1'b1, a});
        end
        flash_mem_waitrequest = 1'b0;
        @(posedge inclk); #1;
        flash_mem_waitrequest = 1'b1;
        lat = $urandom_range(1, 5);
        repeat (lat - 1) begin
          @(posedge inclk); #1;
        end
        flash_mem_readdata      = get_word(a);
        flash_mem_readdatavalid = 1'b1;
        @(posedge inclk); #1;
        flash_mem_readdatavalid = 1'b0;
      end
    end
  end

  // Monitor: each accepted read must target the next expected address.
  initial forever begin
    @(negedge inclk);
    if (mon_en && flash_mem_read && !flash_mem_waitrequest) begin
      if (rd_q.size() == 0) flag("rd_unexpected", 32'(flash_mem_address));
      else check("rd_addr", 32'(flash_mem_address), 32'(rd_q.pop_front()));
    end
  end

  // Monitor: each finished pulse must match the word just completed.
  initial forever begin
    @(negedge inclk);
    if (mon_en && flash_read_finished) begin
      if (fin_q.size() == 0) flag("fin_unexpected", 32'(flash_mem_address));
      else check("fin_addr", 32'(flash_mem_address), 32'(fin_q.pop_front()));
    end
  end

  // Monitor: audio output settles well within a tick period after each tick.
  initial forever begin
    @(negedge inclk);
    if (mon_en && sample_tick) begin
      repeat (20) @(negedge inclk);
      if (aud_q.size() == 0) flag("aud_unexpected", 32'(audio_sample));
      else check("audio", 32'(audio_sample), 32'(aud_q.pop_front()));
    end
  end

  // Reference model state.
  logic [22:0] m_addr;
  bit          m_half;
  bit          m_fwd;
  logic [15:0] m_audio;

  task automatic model_tick(input bit cs, input bit cd, input bit cr);
    logic [31:0] w;
    if (cs) begin
      w = get_word(m_addr);
      if (!m_half) m_audio = m_fwd ? w[15:0]  : w[31:16];
      else         m_audio = m_fwd ? w[31:16] : w[15:0];
      if (m_half) begin
        fin_q.push_back(m_addr);
        if (cr)      m_addr = cd ? 23'd0 : LAST;
        else if (cd) m_addr = (m_addr == LAST) ? 23'd0 : m_addr + 23'd1;
        else         m_addr = (m_addr == 23'd0) ? LAST : m_addr - 23'd1;
        rd_q.push_back(m_addr);
        m_fwd = cd;
      end
      m_half = !m_half;
    end
    aud_q.push_back(m_audio);
  endtask

  bit sc_start [13] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  bit sc_dir   [13] = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  bit sc_rst   [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    bit cs, cd, cr;
    reset = 1'b1; start_read_flash = 1'b0; direction = 1'b1;
    restart = 1'b0; sample_tick = 1'b0;
    repeat (3) @(posedge inclk); #1;
    check("rst_read", 32'(flash_mem_read), 32'd0);
    check("rst_fin", 32'(flash_read_finished), 32'd0);
    check("rst_audio", 32'(audio_sample), 32'd0);
    check("rst_addr", 32'(flash_mem_address), 32'd0);
    check("byteenable", 32'(flash_mem_byteenable), 32'hF);

    reset = 1'b0; start_read_flash = 1'b1;
    @(posedge inclk); #1;
    check("req_read", 32'(flash_mem_read), 32'd1);
    check("req_addr", 32'(flash_mem_address), 32'd0);
    flash_mem_readdata = 32'hDEAD_BEEF; flash_mem_readdatavalid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge inclk); #1;
      flash_mem_readdatavalid = 1'b0;
      check("stall_read", 32'(flash_mem_read), 32'd1);
      check("stall_addr", 32'(flash_mem_address), 32'd0);
    end
    flash_mem_waitrequest = 1'b0;
    @(posedge inclk); #1;
    flash_mem_waitrequest = 1'b1;
    check("accept_read", 32'(flash_mem_read), 32'd0);

    reset = 1'b1; start_read_flash = 1'b0;
    @(posedge inclk); #1;
    reset = 1'b0;
    check("midrst_read", 32'(flash_mem_read), 32'd0);
    check("midrst_fin", 32'(flash_read_finished), 32'd0);
    check("midrst_audio", 32'(audio_sample), 32'd0);
    check("midrst_addr", 32'(flash_mem_address), 32'd0);
    flash_mem_readdata = 32'h5555_AAAA; flash_mem_readdatavalid = 1'b1;
    @(posedge inclk); #1;
    flash_mem_readdatavalid = 1'b0;
    check("idle_read", 32'(flash_mem_read), 32'd0);

    start_read_flash = 1'b1;
    @(posedge inclk); #1;
    check("restart_read", 32'(flash_mem_read), 32'd1);
    check("restart_addr", 32'(flash_mem_address), 32'd0);
    flash_mem_waitrequest = 1'b0;
    @(posedge inclk); #1;
    flash_mem_waitrequest = 1'b1;
    @(posedge inclk); #1;
    flash_mem_readdata = 32'hBBBB_AAAA; flash_mem_readdatavalid = 1'b1;
    @(posedge inclk); #1;
    flash_mem_readdatavalid = 1'b0;
    sample_tick = 1'b1;
    @(posedge inclk); #1;
    sample_tick = 1'b0;
    @(posedge inclk); #1;
    check("dir_first", 32'(audio_sample), 32'h0000_AAAA);
    check("dir_fin0", 32'(flash_read_finished), 32'd0);
    sample_tick = 1'b1;
    @(posedge inclk); #1;
    sample_tick = 1'b0;
    @(posedge inclk); #1;
    check("dir_second", 32'(audio_sample), 32'h0000_BBBB);
    check("dir_fin1", 32'(flash_read_finished), 32'd1);
    @(posedge inclk); #1;
    check("dir_fin_end", 32'(flash_read_finished), 32'd0);
    check("dir_next_addr", 32'(flash_mem_address), 32'd1);
    check("dir_next_read", 32'(flash_mem_read), 32'd1);

    // Scripted then random playback against the reference model.
    reset = 1'b1; start_read_flash = 1'b1; direction = 1'b1; restart = 1'b0;
    repeat (2) @(posedge inclk); #1;
    m_addr = 23'd0; m_half = 1'b0; m_fwd = 1'b1; m_audio = 16'h0000;
    rd_q.push_back(23'd0);
    slave_en = 1'b1; mon_en = 1'b1; reset = 1'b0;
    repeat (40) @(posedge inclk); #1;
    for (int t = 0; t < 163; t++) begin
      if (t < 13) begin
        cs = sc_start[t]; cd = sc_dir[t]; cr = sc_rst[t];
      end else begin
        cs = ($urandom_range(0, 7) != 0);
        cd = ($urandom_range(0, 3) == 0) ? !direction : direction;
        cr = ($urandom_range(0, 7) == 0);
      end
      start_read_flash = cs; direction = cd; restart = cr;
      repeat (30) @(posedge inclk); #1;
      model_tick(cs, cd, cr);
      sample_tick = 1'b1;
      @(posedge inclk); #1;
      sample_tick = 1'b0;
      repeat (29) @(posedge inclk); #1;
    end
    start_read_flash = 1'b1;
    repeat (40) @(posedge inclk); #1;
    mon_en = 1'b0;
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("fin_q_drained", 32'(fin_q.size()), 32'd0);
    check("aud_q_drained", 32'(aud_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flash_sample_reader.md
Name: flash_sample_reader

Overview:
- Playback engine directly downstream of keyboard_control; consumes its direction, start_read_flash and restart outputs, and produces the flash_read_finished it waits on.
- Reads 32-bit words from the on-board flash over an Avalon-MM read master.
- Splits each word into two signed 16-bit audio samples and presents one sample per audio-rate tick, in forward or backward order, wrapping at the ends of the sample region.

Parameters:
- ADDR_W, 23, flash word-address width.
- LAST_ADDR, 23'h7FFFF, last word address of the sample region; first is 0.

Ports:
- inclk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start_read_flash  input  1  1 = play, 0 = pause.
- direction  input  1  1 = forward, 0 = backward.
- restart  input  1  jump to start of region (per direction) at next word boundary.
- sample_tick  input  1  one-cycle audio-rate strobe (e.g. 22 kHz) from a clock divider.
- flash_mem_read  output  1  Avalon read request.
- flash_mem_address  output  ADDR_W  word address.
- flash_mem_byteenable  output  4  constant 4'hF.
- flash_mem_waitrequest  input  1  Avalon waitrequest.
- flash_mem_readdata  input  32  read data.
- flash_mem_readdatavalid  input  1  read data valid.
- audio_sample  output  16  current sample to audio codec.
- flash_read_finished  output  1  one-cycle pulse per completed word.

Behaviour:
- Reset (sync, dominates everything): state IDLE, address 0, audio_sample 16'h0000, flash_mem_read 0, flash_read_finished 0, tick_pending 0, word latch 0.
- Tick capture: sample_tick sets tick_pending, which is cleared on the consuming cycle.
  - While tick_pending is already 1, further ticks are dropped.
  - Ticks are ignored while start_read_flash = 0.
- FSM states and transitions:
  - IDLE: go to REQ when start_read_flash = 1.
  - REQ: flash_mem_read = 1, address held stable. Go to WAIT_DATA on the cycle flash_mem_waitrequest = 0.
  - WAIT_DATA: go to OUT_FIRST on flash_mem_readdatavalid, latching readdata.
  - OUT_FIRST: on tick_pending && start_read_flash, output first half, then go to OUT_SECOND.
  - OUT_SECOND: on tick_pending && start_read_flash, output second half, then go to ADVANCE.
  - ADVANCE: pulse flash_read_finished for 1 cycle, update address, then go to REQ if start_read_flash = 1, else IDLE.
- Half order:
  - Forward: first = readdata[15:0], second = readdata[31:16].
  - Backward: first = [31:16], second = [15:0].
  - Order is fixed from direction sampled on entry to OUT_FIRST.
- audio_sample is registered: it updates the cycle after the consuming tick and holds its value otherwise, including while paused.
- Address update in ADVANCE, evaluated in this priority order:
  - restart = 1: forward → 0, backward → LAST_ADDR.
  - Forward: LAST_ADDR wraps to 0, else +1.
  - Backward: 0 wraps to LAST_ADDR, else −1.
  - Direction is sampled in ADVANCE.
- Pause mid-transaction: an outstanding Avalon read is never aborted; REQ/WAIT_DATA complete normally, then the FSM stalls in OUT_FIRST/OUT_SECOND until play resumes.
- Direction change mid-word does not affect the current word; it takes effect on that word's address update.
- A restart held for several words re-applies at each ADVANCE. keyboard_control clears restart on flash_read_finished.
- Reset mid-read: flash_mem_read drops the next cycle. A stale readdatavalid arriving in IDLE or REQ is ignored.
- Throughput: the worst-case word fetch must complete within one tick period. If the fetch is late, tick_pending holds the tick and the output is delayed, not skipped.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, REQ, WAIT_DATA, OUT_FIRST, OUT_SECOND, ADVANCE.
  - Direction constants FWD = 1, BWD = 0.
  - Constants FLASH_FIRST_ADDR = 0 and FLASH_LAST_ADDR.
- One natural sub-module: flash_addr_counter (up/down wrap counter with synchronous load-to-start), instantiated once.

Test Plan:
- Forward play: reset, direction = 1, start = 1; flash model returns 32'hBBBB_AAAA at addr 0 and 32'hDDDD_CCCC at addr 1; 4 ticks → audio_sample sequence AAAA, BBBB, CCCC, DDDD; flash_read_finished pulses twice; address 0→1→2.
- Backward play with wrap: direction = 0 from addr 0, word 32'h1234_5678 → outputs 1234 then 5678; next flash_mem_address = 23'h7FFFF.
- Forward wrap: force address to LAST_ADDR, play one word (2 ticks) → next read address 0.
- Restart: at addr 5 forward, assert restart; after the next 2 ticks the next REQ address is 0. In backward mode the same sequence yields 23'h7FFFF.
- Pause/waitrequest: hold waitrequest high for 7 cycles → read and address stay stable. Deassert start mid-WAIT_DATA → the read completes; ticks while paused → audio_sample unchanged and no flash_read_finished.
- Reset mid-read: assert reset during WAIT_DATA → all outputs are 0 next cycle; a late readdatavalid is ignored; restart from address 0.
